// File: rtl/lsu.sv
// Load/store unit: runs one word-aligned req/ack data-bus transaction per accepted start,
// steering store lanes, extending load data, and flagging misalignment and bus timeouts.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        mem_wen,
  input  logic [1:0]  mem_size,
  input  logic        is_mem_sign,
  input  logic [3:0]  mem_wbmask,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_wen,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBus  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // The counter value seen in the last BUS cycle allowed before aborting.
  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] addr_q;
  logic        wen_q;
  logic        sign_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;

  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        bad_mask;
  logic        accept;
  logic [31:0] shifted;
  logic [31:0] load_val;

  // Stores take their access width from the byte mask, loads from mem_size.
  always_comb begin
    is_half    = mem_wen ? (mem_wbmask == 4'b0011) : (mem_size == 2'b01);
    is_word    = mem_wen ? (mem_wbmask == 4'b1111) : mem_size[1];
    misaligned = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
    bad_mask   = mem_wen & (mem_wbmask != 4'b0001) & (mem_wbmask != 4'b0011) &
                 (mem_wbmask != 4'b1111);
    accept     = (state_q == StIdle) & start & ~misaligned & ~bad_mask;
  end

  always_comb begin
    shifted = bus_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   load_val = {{24{sign_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (misaligned | bad_mask) begin
            state_d = StDone;
            err_d   = misaligned;
          end else begin
            state_d = StBus;
            cnt_d   = 8'd0;
            err_d   = 1'b0;
          end
        end
      end
      StBus: begin
        if (bus_ack) begin
          state_d = StDone;
          err_d   = 1'b0;
          if (!wen_q) begin
            rdata_d = load_val;
          end
        end else if (cnt_q == CntLast) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end
      default: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus-facing request fields are captured once at acceptance and held for the whole access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= 32'd0;
      wen_q   <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= 2'b00;
      wstrb_q <= 4'b0000;
      wdata_q <= 32'd0;
    end else if (accept) begin
      addr_q  <= addr;
      wen_q   <= mem_wen;
      sign_q  <= is_mem_sign;
      size_q  <= mem_size;
      wstrb_q <= mem_wen ? (mem_wbmask << addr[1:0]) : 4'b0000;
      wdata_q <= wdata << {addr[1:0], 3'b000};
    end
  end

  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    err       = err_q;
    rdata     = rdata_q;
    bus_req   = (state_q == StBus);
    bus_wen   = wen_q & (state_q == StBus);
    bus_addr  = {addr_q[31:2], 2'b00};
    bus_wstrb = wstrb_q;
    bus_wdata = wdata_q;
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a transaction-level model sets per-cycle expectations that one
// compare process checks, plus literal pins taken from hand-computed values.
module tb_lsu;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        mem_wen = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic        is_mem_sign = 1'b0;
  logic [3:0]  mem_wbmask = 4'b0000;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, err, bus_req, bus_wen;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mem_wen(mem_wen),
    .mem_size(mem_size), .is_mem_sign(is_mem_sign), .mem_wbmask(mem_wbmask),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .bus_req(bus_req), .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clock = ~clock;

  // Expectations for the current cycle, written only by the stimulus process.
  logic        exp_busy = 1'b0, exp_req = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
  logic        exp_wen = 1'b0;
  logic [31:0] exp_rdata = 32'd0, exp_addr = 32'd0, exp_wdata = 32'd0;
  logic [3:0]  exp_wstrb = 4'd0;
  int          pin_seq = 0, pin_kind = 0;
  logic [31:0] pin_want = 32'd0;

  // Written only by the compare process.
  int          vectors = 0, miscompares = 0, done_cnt = 0, pin_seen = 0;
  logic [31:0] last_addr = 32'd0, last_wdata = 32'd0;
  logic [3:0]  last_wstrb = 4'd0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h at %0t", name, got, want, $time);
    end
  endtask

  always begin
    @(posedge clock or negedge reset_n);
    #1;
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("bus_req", 32'(bus_req), 32'(exp_req));
    chk("done", 32'(done), 32'(exp_done));
    chk("rdata", rdata, exp_rdata);
    if (exp_done) chk("err", 32'(err), 32'(exp_err));
    if (exp_req) begin
      chk("bus_addr", bus_addr, exp_addr);
      chk("bus_wen", 32'(bus_wen), 32'(exp_wen));
      chk("bus_wstrb", 32'(bus_wstrb), 32'(exp_wstrb));
      if (exp_wen) chk("bus_wdata", bus_wdata, exp_wdata);
    end
    if (bus_req) begin
      last_addr  = bus_addr;
      last_wstrb = bus_wstrb;
      last_wdata = bus_wdata;
    end
    if (done) done_cnt++;
    if (pin_seq != pin_seen) begin
      case (pin_kind)
        0:       chk("pin_rdata", rdata, pin_want);
        1:       chk("pin_wstrb", 32'(last_wstrb), pin_want);
        2:       chk("pin_wdata", last_wdata, pin_want);
        3:       chk("pin_addr", last_addr, pin_want);
        default: chk("pin_done_count", 32'(done_cnt), pin_want);
      endcase
      pin_seen = pin_seq;
    end
  end

  // Request side of the model: width from mask (store) or size (load), lane = addr mod 4.
  task automatic model_req(input logic wen, input logic [1:0] size, input logic [3:0] mask,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic bad_align, output logic bad_mask,
                           output logic [3:0] strb, output logic [31:0] wdo);
    int lane;
    int nb;
    lane = int'(a[1:0]);
    if (wen) nb = (mask == 4'b0001) ? 1 : (mask == 4'b0011) ? 2 : (mask == 4'b1111) ? 4 : 0;
    else     nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    bad_mask  = (nb == 0);
    bad_align = !bad_mask && ((lane % nb) != 0);
    strb      = wen ? 4'(int'(mask) * (1 << lane)) : 4'b0000;
    wdo       = 32'(longint'(wd) * (longint'(1) << (8 * lane)));
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] size,
                                             input logic sign, input logic [31:0] rd);
    int     lane;
    int     nb;
    longint v;
    lane = int'(a[1:0]);
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    v    = (longint'(rd) >> (8 * lane)) % (longint'(1) << (8 * nb));
    if (sign && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  task automatic set_exp(input logic b, input logic r, input logic d, input logic e);
    exp_busy = b;
    exp_req  = r;
    exp_done = d;
    exp_err  = e;
  endtask

  task automatic scramble();
    mem_wen     = 1'($urandom);
    mem_size    = 2'($urandom);
    is_mem_sign = 1'($urandom);
    mem_wbmask  = 4'($urandom);
    addr        = $urandom;
    wdata       = $urandom;
  endtask

  // One access; ack_at > TO means no ack is ever given. poke pulses start while busy.
  task automatic run(input logic wen, input logic [1:0] size, input logic sign,
                     input logic [3:0] mask, input logic [31:0] a, input logic [31:0] wd,
                     input int ack_at, input logic [31:0] rd, input bit poke);
    logic bad_align, bad_mask;
    logic [3:0]  m_strb;
    logic [31:0] m_wdata;
    model_req(wen, size, mask, a, wd, bad_align, bad_mask, m_strb, m_wdata);
    @(negedge clock);
    start = 1'b1; mem_wen = wen; mem_size = size; is_mem_sign = sign;
    mem_wbmask = mask; addr = a; wdata = wd; bus_ack = 1'b0;
    exp_addr = a - (a % 4); exp_wen = wen; exp_wstrb = m_strb; exp_wdata = m_wdata;
    if (bad_align || bad_mask) begin
      set_exp(1'b1, 1'b0, 1'b1, bad_align);
      @(negedge clock);
      start = 1'b0; scramble(); set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      set_exp(1'b1, 1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 300; c++) begin
        @(negedge clock);
        scramble();
        start     = poke && (c == 1 || c == ack_at);
        bus_ack   = (c == ack_at);
        bus_rdata = (c == ack_at) ? rd : $urandom;
        if (c == ack_at) begin
          set_exp(1'b1, 1'b0, 1'b1, 1'b0);
          if (!wen) exp_rdata = model_load(a, size, sign, rd);
          break;
        end
        if (c == TO) begin
          set_exp(1'b1, 1'b0, 1'b1, 1'b1);
          break;
        end
      end
      @(negedge clock);
      start = 1'b0; bus_ack = 1'b0; scramble(); set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic pin(input int kind, input logic [31:0] want);
    @(negedge clock);
    start = 1'b0; bus_ack = 1'b0;
    pin_kind = kind; pin_want = want; pin_seq++;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    run(1'b1, 2'd0, 1'b0, 4'b0001, 32'h0000_1003, 32'h0000_00AB, 3, 32'd0, 1'b0);
    pin(1, 32'h0000_0008);
    pin(2, 32'hAB00_0000);
    pin(3, 32'h0000_1000);

    run(1'b0, 2'd0, 1'b1, 4'b0000, 32'h0000_2002, 32'd0, 1, 32'h1280_7856, 1'b0);
    pin(0, 32'hFFFF_FF80);
    run(1'b0, 2'd0, 1'b0, 4'b0000, 32'h0000_2002, 32'd0, 1, 32'h1280_7856, 1'b0);
    pin(0, 32'h0000_0080);
    run(1'b0, 2'd1, 1'b1, 4'b0000, 32'h0000_2002, 32'd0, 2, 32'h8001_1234, 1'b0);
    pin(0, 32'hFFFF_8001);
    run(1'b0, 2'd2, 1'b1, 4'b0000, 32'h0000_2000, 32'd0, 1, 32'h8001_1234, 1'b0);
    pin(0, 32'h8001_1234);
    run(1'b0, 2'd3, 1'b1, 4'b0000, 32'h0000_2000, 32'd0, 1, 32'h8765_4321, 1'b0);
    pin(0, 32'h8765_4321);

    run(1'b1, 2'd1, 1'b0, 4'b0011, 32'h0000_5002, 32'h0000_1234, 2, 32'd0, 1'b0);
    pin(1, 32'h0000_000C);
    pin(2, 32'h1234_0000);

    // Misaligned word load, misaligned half store, illegal store mask.
    run(1'b0, 2'd2, 1'b0, 4'b0000, 32'h0000_2001, 32'd0, 1, 32'hFFFF_FFFF, 1'b0);
    run(1'b1, 2'd1, 1'b0, 4'b0011, 32'h0000_3003, 32'h0000_5555, 1, 32'd0, 1'b0);
    run(1'b1, 2'd0, 1'b0, 4'b0101, 32'h0000_1000, 32'h0000_5555, 1, 32'd0, 1'b0);

    // Timeout leaves rdata alone; a stray ack afterwards changes nothing.
    run(1'b0, 2'd2, 1'b0, 4'b0000, 32'h0000_2000, 32'd0, 99, 32'd0, 1'b0);
    pin(0, 32'h8765_4321);
    @(negedge clock);
    bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
    @(negedge clock);
    bus_ack = 1'b0;
    run(1'b0, 2'd1, 1'b0, 4'b0000, 32'h0000_2000, 32'd0, 1, 32'hCAFE_F00D, 1'b0);
    pin(0, 32'h0000_F00D);

    run(1'b1, 2'd2, 1'b0, 4'b1111, 32'h0000_4000, 32'hDEAD_BEEF, 2, 32'd0, 1'b1);
    pin(2, 32'hDEAD_BEEF);
    pin(1, 32'h0000_000F);

    // Reset dropped during BUS: outputs fall immediately, no done follows.
    @(negedge clock);
    start = 1'b1; mem_wen = 1'b0; mem_size = 2'd2; is_mem_sign = 1'b0;
    mem_wbmask = 4'b0000; addr = 32'h0000_6000;
    exp_addr = 32'h0000_6000; exp_wen = 1'b0; exp_wstrb = 4'b0000;
    set_exp(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    #2;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    exp_rdata = 32'd0;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    run(1'b0, 2'd2, 1'b0, 4'b0000, 32'h0000_2000, 32'd0, 1, 32'h0BAD_CAFE, 1'b0);
    pin(0, 32'h0BAD_CAFE);
    pin(4, 32'd14);

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
